fifo_sync_flags: RTL and testbench

//  Parametrised single-clock FIFO, successor to the lab FIFO.

---
 rtl/fifo_sync_flags.sv | 153 +++++++++++++++
 tb/tb_fifo_sync_flags.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with an occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// read-valid strobe.
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through output.
// In that mode dout always shows the head word and dout_valid mirrors !empty.
// Without it, dout is registered and updated one cycle after an accepted read.
module fifo_sync_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  // write side
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             almost_full,
  // read side
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             empty,
  output logic             almost_empty,
  // status
  output logic [PTR_W:0]   count,
  input  logic             clr_err,
  output logic             overflow,
  output logic             underflow
);

  localparam int CNT_W = PTR_W + 1;

  // Thresholds resized once so every count comparison is width-matched.
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] P_ONE   = PTR_W'(1);

  // Storage (intentionally not reset) and control state.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  // Handshake decode and next-state values.
  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [CNT_W-1:0] w_count_nxt;

  // Flags are pure decodes of the registered count.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);

  // A read is taken whenever data exists. A write is taken when there is room,
  // or when a same-cycle read frees the slot it will land in (full wr+rd case).
  assign w_rd_acc  = rd_en & ~w_empty;
  assign w_wr_acc  = wr_en & (~w_full | w_rd_acc);

  // Error events: a write that was dropped, a read of an empty FIFO.
  assign w_ovf_evt = wr_en & ~w_wr_acc;
  assign w_unf_evt = rd_en & w_empty;

  // Occupancy moves only when exactly one side of the transfer happens.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage write; on full wr+rd wptr equals rptr, and the read below still
  // captures the old word because both sample the array before this update.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**PTR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + P_ONE;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + P_ONE;
      end
      r_count <= w_count_nxt;
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_evt | (r_overflow  & ~clr_err);
      r_underflow <= w_unf_evt | (r_underflow & ~clr_err);
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented combinationally; rd_en acknowledges it.
  assign dout       = r_mem[r_rptr];
  assign dout_valid = ~w_empty;
`else
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;

  // Registered read port: one-cycle latency, dout holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_dout <= r_mem[r_rptr];
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
`endif

  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags with a queue-based reference model.
module tb_fifo_sync_flags;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int PTR_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             full, almost_full, empty, almost_empty;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [PTR_W:0]   count;
  logic             overflow, underflow;

  fifo_sync_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid),
    .empty(empty), .almost_empty(almost_empty), .count(count),
    .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_rd  = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int c;
    c = q.size();
    chk({tag, ".count"},  32'(count),        32'(c));
    chk({tag, ".empty"},  32'(empty),        32'(c == 0));
    chk({tag, ".full"},   32'(full),         32'(c == DEPTH));
    chk({tag, ".afull"},  32'(almost_full),  32'(c >= AF));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(c <= AE));
    chk({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
    chk({tag, ".unf"},    32'(underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
    chk({tag, ".valid"}, 32'(dout_valid), 32'(c != 0));
    if (c != 0) chk({tag, ".dout"}, 32'(dout), 32'(q[0]));
`else
    chk({tag, ".valid"}, 32'(dout_valid), 32'(m_rd));
    chk({tag, ".dout"},  32'(dout),       32'(m_dout));
`endif
  endtask

  // One clock of stimulus; expected effects are derived from the model
  // state before the edge, then checked one step after the edge.
  task automatic step(input logic wr, input logic [WIDTH-1:0] d, input logic rd,
                      input logic clr, input string tag);
    bit rd_acc, wr_acc;
    wr_en = wr; din = d; rd_en = rd; clr_err = clr;
    rd_acc = rd && (q.size() != 0);
    wr_acc = wr && ((q.size() < DEPTH) || rd_acc);
    if (rd_acc) m_dout = q.pop_front();
    if (wr_acc) q.push_back(d);
    m_ovf = (wr && !wr_acc) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (rd && !rd_acc) ? 1'b1 : (clr ? 1'b0 : m_unf);
    m_rd  = rd_acc;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
    check_state(tag);
  endtask

  // Assert reset between edges and check its effect before any clock.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_dout = '0; m_rd = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    check_state(tag);
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_state("por");
    rst_n = 1'b1;

    // Async reset in mid-stream with five words stored
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'hC0 + i), 1'b0, 1'b0, "pre_rst");
    async_reset("mid_rst");
    step(1'b0, '0, 1'b0, 1'b0, "post_rst");

    // Fill to full, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, "fill");
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");
    step(1'b0, '0, 1'b0, 1'b0, "idle");

    // Pointer wrap: 20 in / 20 out twice
    for (int i = 0; i < 20; i++) step(1'b1, WIDTH'(100 + i), 1'b0, 1'b0, "wrap_w1");
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0, "wrap_r1");
    for (int i = 0; i < 20; i++) step(1'b1, WIDTH'(200 + i), 1'b0, 1'b0, "wrap_w2");
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0, "wrap_r2");

    // Simultaneous write and read while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0, 1'b0, "full_fill");
    step(1'b1, 8'hEE, 1'b1, 1'b0, "full_wr_rd");
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, "full_drain");

    // Overflow, clear, clear racing a new error, data integrity
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(8'h60 + i), 1'b0, 1'b0, "err_fill");
    step(1'b1, 8'h99, 1'b0, 1'b0, "ovf_set");
    step(1'b0, '0, 1'b0, 1'b1, "ovf_clr");
    step(1'b1, 8'h98, 1'b0, 1'b1, "ovf_wins");
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, "err_drain");

    // Underflow, write+read while empty, clear of both flags
    step(1'b0, '0, 1'b1, 1'b0, "unf_set");
    step(1'b1, 8'h33, 1'b1, 1'b0, "empty_wr_rd");
    step(1'b0, '0, 1'b0, 1'b1, "err_clr");
    step(1'b0, '0, 1'b1, 1'b0, "read_33");

    // Single word into an empty FIFO, then pop it
    step(1'b1, 8'hA5, 1'b0, 1'b0, "a5_write");
    step(1'b0, '0, 1'b0, 1'b0, "a5_hold");
    step(1'b0, '0, 1'b1, 1'b0, "a5_pop");
    step(1'b0, '0, 1'b0, 1'b0, "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
